// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-to-decode handshake bundle.
// Carries the queue head and decode's accept signal.
interface fetch_unit_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_misaligned;

  modport master (
    output if_valid,
    output if_pc,
    output if_instruction,
    output if_misaligned,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_instruction,
    input  if_misaligned,
    output if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pc_one core.
// Owns the fetch PC, buffers {pc, instr} pairs for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_pc,
  input  logic [31:0] rom_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_unit_if.master dec
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  entry_t          mem_q [QDEPTH];
  logic [31:0]     fpc_q, fpc_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            halt_q, halt_d;
  logic            fault_q, fault_d;
  logic            pop;
  logic            we;
  logic            tgt_mis;
  entry_t          went;

  assign rom_pc  = fpc_q;
  assign pop     = (cnt_q != '0) && dec.if_ready;
  assign tgt_mis = |redirect_pc[1:0];

  // Next-state: redirect flushes, else pop head and push fetched word.
  always_comb begin
    fpc_d   = fpc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    fault_d = fault_q;
    we      = 1'b0;
    went    = '{pc: fpc_q, instr: rom_instruction, mis: 1'b0};
    if (redirect_valid) begin
      fpc_d   = redirect_pc;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      halt_d  = tgt_mis;
      fault_d = tgt_mis;
    end else begin
      if (fault_q) begin
        we      = 1'b1;
        went    = '{pc: fpc_q, instr: NOP_INSTR, mis: 1'b1};
        fault_d = 1'b0;
      end else if (!halt_q &&
                   (cnt_q < CW'(QDEPTH) || pop)) begin
        we    = 1'b1;
        fpc_d = fpc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + PW'(1);
      if (we)  wr_d = wr_q + PW'(1);
      cnt_d = cnt_q + CW'(we) - CW'(pop);
    end
  end

  // Control state; reset wins over any redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q   <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fpc_q   <= fpc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      fault_q <= fault_d;
    end
  end

  // Queue storage; contents only matter where count says so.
  always_ff @(posedge clk) begin
    if (!rst && we) mem_q[wr_q] <= went;
  end

  // Head presentation; empty queue shows a NOP bubble.
  always_comb begin
    dec.if_valid       = 1'b0;
    dec.if_pc          = '0;
    dec.if_instruction = NOP_INSTR;
    dec.if_misaligned  = 1'b0;
    if (cnt_q != '0) begin
      dec.if_valid       = 1'b1;
      dec.if_pc          = mem_q[rd_q].pc;
      dec.if_instruction = mem_q[rd_q].instr;
      dec.if_misaligned  = mem_q[rd_q].mis;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pc_one core. It sits directly upstream of the instruction ROM: it owns the fetch program counter, drives the ROM's instruction-address port, and captures the combinationally returned word. It buffers fetched {pc, instruction} pairs in a small queue and presents them to decode through a valid/ready handshake. It also accepts redirects (branches, jumps, traps) from execute and flushes wrong-path instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address loaded on reset.
- `QDEPTH`, default 2: queue entries; power of two, ≥ 2.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0): word driven when the queue is empty or a fault is flagged.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_pc`  out  32  byte address to the ROM instruction port; equals the fetch PC register.
- `rom_instruction`  in  32  ROM word for `rom_pc`, valid in the same cycle (combinational ROM).
- `redirect_valid`  in  1  one-cycle pulse: discard all queued and in-flight work and restart at `redirect_pc`.
- `redirect_pc`  in  32  redirect target byte address.
- `if_valid`  out  1  queue head holds a valid entry.
- `if_ready`  in  1  decode accepts the head this cycle.
- `if_pc`  out  32  PC of the head entry.
- `if_instruction`  out  32  instruction of the head entry.
- `if_misaligned`  out  1  head entry is an instruction-address-misaligned fault.

## Operation
- State:
  - fetch PC register `fpc`.
  - QDEPTH-entry circular queue of {pc, instr, misaligned}, with read pointer, write pointer and a count of width log2(QDEPTH)+1.
  - `halted` flag.
- `rom_pc = fpc` at all times.
- Pop: `if_valid && if_ready`. Head advances and count decrements.
- Push: happens when `!halted`, no redirect, and (count < QDEPTH or pop this cycle). The pushed entry is {fpc, rom_instruction, 0}, and `fpc <= fpc + 4`.
  - Addition is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - Full queue with no pop: `fpc` holds and nothing is written.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
- Redirect has priority over push and pop:
  - Queue is emptied (count=0, pointers equal).
  - A same-cycle pop is void; decode must discard it.
  - `fpc <= redirect_pc`.
  - `halted` is cleared, unless the target is misaligned.
- Misaligned target (`redirect_pc[1:0] != 0`):
  - `fpc <= redirect_pc` and `halted <= 1`.
  - The next cycle pushes exactly one entry {redirect_pc, NOP_INSTR, 1}.
  - No further pushes occur while halted. Only `rst` or a new redirect leaves halt.
- Outputs:
  - When count = 0: `if_valid`=0, `if_pc`=0, `if_instruction`=NOP_INSTR, `if_misaligned`=0.
  - Otherwise they mirror the head entry.
- No ROM access is made to addresses beyond the ROM size. Out-of-range addresses are the ROM's concern.

## Timing
- Reset, applied at any point including mid-stream:
  - Takes effect at the next edge.
  - Afterwards: `fpc`=RESET_PC, queue empty, `halted`=0, `if_valid`=0, `if_pc`=0, `if_instruction`=NOP_INSTR, `if_misaligned`=0.
  - Reset overrides redirect.
- First cycle after reset release (cycle 0): `rom_pc`=RESET_PC. The entry is pushed at the end of cycle 0, and `if_valid`=1 with `if_pc`=RESET_PC in cycle 1.
- Fetch-to-decode latency: 1 cycle. Sustained throughput is 1 instruction/cycle while `if_ready`=1.
- Redirect asserted in cycle N:
  - `if_valid`=0 in N+1.
  - `rom_pc`=redirect_pc in N+1.
  - Target entry presented in N+2.
- Backpressure with `if_ready`=0 from cycle N, queue empty at N:
  - Pushes happen in N and N+1.
  - Queue is full from N+2 onward. `rom_pc` then holds at the address of the third instruction.
- `if_*` outputs are stable while `if_valid && !if_ready` and no redirect is present.

## Test plan
- **Reset and stream.** Reset, then `if_ready`=1, ROM word at address 4k = k.
  - `if_valid` rises in cycle 1.
  - Consecutive cycles give `if_pc` 0,4,8,12 with `if_instruction` 0,1,2,3.
- **Backpressure.** Hold `if_ready`=0 for 5 cycles, then release.
  - Queue stops at 2 entries and `rom_pc` freezes.
  - After release, the sequence continues with no gap or duplicate.
- **Redirect flush.** Assert `redirect_valid` with `redirect_pc`=32'h0000_0100 while the queue is full and `if_ready`=1.
  - Next cycle `if_valid`=0.
  - Following cycle `if_pc`=32'h100.
  - No stale PCs appear.
- **Misaligned redirect.** Redirect to 32'h0000_0102.
  - One entry appears with `if_pc`=32'h102, `if_instruction`=32'h0000_0013, `if_misaligned`=1.
  - Then `if_valid` stays 0 for 10 cycles.
  - A redirect to 32'h200 resumes fetch.
- **Wrap-around.** Redirect to 32'hFFFF_FFF8.
  - PCs observed: FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Reset mid-operation.** Assert `rst` together with `redirect_valid` on a full queue.
  - After the edge: queue empty, `rom_pc`=RESET_PC, and all outputs at their reset values.
